arith_resp_checker: RTL and testbench
=====================================

// Module: arith_resp_checker
// PURPOSE
//  Hardware response checker for the 1-bit arithmetic unit (sum c, carry d, borrow e).
//  Accepts {a,b,c,d,e} result vectors over a valid/ready handshake.
//  Compares each vector against a golden half-adder/half-subtractor model.
//  Counts vectors and mismatches, captures the first failing index, and reports pass/fail after NUM_VECTORS.
//  Sits downstream of the arithmetic DUT in self-checking benches and on-chip BIST.
// PARAMETERS
//  NUM_VECTORS  4  vectors per run; must be >=1 and <= 2**CNT_W-1
//  CNT_W        8  width of vector/error counters and fail index
// PORTS
//  clk               in   1      single clock, rising edge
//  rst               in   1      synchronous, active-high reset
//  start             in   1      1-cycle pulse; begins a run (IDLE or DONE only)
//  in_valid          in   1      vector present on a..e
//  in_ready          out  1      checker accepts vector this cycle
//  a, b              in   1      operands as applied to DUT
//  c, d, e           in   1      DUT outputs: sum, carry, borrow
//  busy              out  1      run in progress
//  done              out  1      run complete (level, held until start/rst)
//  pass              out  1      valid when done; 1 = zero mismatches
//  vec_count         out  CNT_W  vectors accepted this run
//  err_count         out  CNT_W  mismatching vectors this run, saturating
//  first_fail_valid  out  1      a mismatch has been captured this run
//  first_fail_idx    out  CNT_W  vec_count value of first mismatching vector
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0 (in_ready, busy, done, pass, counts, fail regs).
//  Golden model: exp_c=a^b, exp_d=a&b, exp_e=~a&b; mismatch if any of c/d/e differs.
//  FSM IDLE --start--> RUN --last vector accepted--> DONE --start--> RUN.
//   RUN is entered on the cycle after start.
//   Entering RUN clears vec_count, err_count, first_fail_*, done, and pass.
//  in_ready = (state==RUN); busy = (state==RUN). A handshake is in_valid & in_ready.
//  On handshake (1-cycle latency, registered):
//   - vec_count += 1.
//   - On mismatch, err_count += 1, saturating at 2**CNT_W-1.
//   - On the first mismatch only: first_fail_valid=1 and first_fail_idx=pre-increment vec_count.
//  Last vector is the handshake with vec_count==NUM_VECTORS-1.
//   Next cycle: state=DONE, done=1, busy=0, in_ready=0.
//   pass=(final err_count==0), including any mismatch on the last vector.
//  in_valid outside RUN: ignored, no counter change.
//  start during RUN: ignored. start in DONE: restarts (clears as above).
//  start and in_valid in the same cycle in IDLE/DONE: the vector is not accepted.
//  rst mid-run: immediate return to IDLE with all outputs cleared, regardless of other inputs.
//  Outputs hold their values in DONE until the next start or rst.
// STRUCTURE
//  arith_pkg: FSM state localparams (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the golden-model function arith_expect(a,b)->{c,d,e}.
//  Sub-module arith_ref_model: combinational golden model wrapping arith_expect.
//   Reused by the top-level arithmetic bench.
//  Top: FSM, counters, first-fail capture, pass logic.
// TESTING
//  1 All-pass: start; the 4 vectors (00,01,10,11) with correct c/d/e.
//    -> done 1 cycle after the 4th handshake, pass=1, vec_count=4, err_count=0, first_fail_valid=0.
//  2 Single fault: vector 2 (a=1,b=0) drives c=0.
//    -> err_count=1, first_fail_valid=1, first_fail_idx=2, pass=0.
//  3 Multi fault: every vector has e inverted.
//    -> err_count=4, first_fail_idx=0; in_valid held 5 cycles, 5th ignored, vec_count=4.
//  4 Protocol: in_valid=1 in IDLE for 3 cycles, then start in RUN mid-run.
//    -> no counts in IDLE, mid-run start ignored, in_ready low outside RUN.
//  5 Reset mid-run: rst after 2 handshakes.
//    -> next cycle all outputs 0, state IDLE; a fresh run then completes with pass=1.
//  6 Restart and saturation (CNT_W=2, NUM_VECTORS=3): start from DONE, all vectors wrong.
//    -> counters cleared on restart, err_count=3 and holds at 3, pass=0.

Source files
------------

// File: rtl/arith_pkg.sv
// Shared definitions for the 1-bit arithmetic response checker.
// Holds the checker FSM encoding and the golden half-adder/half-subtractor function.
package arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Result order is {sum, carry, borrow}, which matches the {c,d,e} port order.
  function automatic logic [2:0] arith_expect(input logic a, input logic b);
    return {a ^ b, a & b, ~a & b};
  endfunction

endpackage

// File: rtl/arith_ref_model.sv
// Combinational golden model for the 1-bit arithmetic unit.
// The top-level arithmetic bench uses this module as well.
module arith_ref_model
  import arith_pkg::*;
(
  input  logic a,
  input  logic b,
  output logic exp_c,
  output logic exp_d,
  output logic exp_e
);

  assign {exp_c, exp_d, exp_e} = arith_expect(a, b);

endmodule

// File: rtl/arith_resp_checker.sv
// Checks {a,b,c,d,e} result vectors against the golden model over valid/ready.
// Counts vectors and mismatches, records the first failing index, and reports pass/fail.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting vectors until NUM_VECTORS have been seen
// DONE  | results held; start begins a new run
module arith_resp_checker
  import arith_pkg::*;
#(
  parameter int NUM_VECTORS = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  input  logic             e,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_fail_valid,
  output logic [CNT_W-1:0] first_fail_idx
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_VECTORS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX  = '1;
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  state_t           state;
  logic             exp_c, exp_d, exp_e;
  logic             mismatch;
  logic             hs;
  logic [CNT_W-1:0] err_next;

  arith_ref_model u_ref (
    .a     (a),
    .b     (b),
    .exp_c (exp_c),
    .exp_d (exp_d),
    .exp_e (exp_e)
  );

  assign mismatch = (c != exp_c) || (d != exp_d) || (e != exp_e);
  assign hs       = in_valid & in_ready;
  // Error count saturates so a long faulty run cannot wrap back to zero and look clean.
  assign err_next = (mismatch && (err_count != ERR_MAX)) ? err_count + ONE : err_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      in_ready         <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      vec_count        <= '0;
      err_count        <= '0;
      first_fail_valid <= 1'b0;
      first_fail_idx   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state            <= RUN;
            in_ready         <= 1'b1;
            busy             <= 1'b1;
            done             <= 1'b0;
            pass             <= 1'b0;
            vec_count        <= '0;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_idx   <= '0;
          end
        end
        RUN: begin
          if (hs) begin
            vec_count <= vec_count + ONE;
            err_count <= err_next;
            if (mismatch && !first_fail_valid) begin
              first_fail_valid <= 1'b1;
              first_fail_idx   <= vec_count;
            end
            // pass uses err_next so a mismatch on the final vector is reflected.
            if (vec_count == LAST_IDX) begin
              state    <= DONE;
              in_ready <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              pass     <= (err_next == '0);
            end
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_arith_resp_checker.sv
// Directed bench for arith_resp_checker: default instance (4 vectors, 8-bit counts)
// plus a narrow instance (3 vectors, 2-bit counts) for restart and saturation.
module tb_arith_resp_checker;

  logic       clk = 1'b0;
  logic       rst, start, start2, in_valid, a, b, c, d, e;
  logic       in_ready, busy, done, pass, first_fail_valid;
  logic [7:0] vec_count, err_count, first_fail_idx;
  logic       in_ready2, busy2, done2, pass2, first_fail_valid2;
  logic [1:0] vec_count2, err_count2, first_fail_idx2;

  int passed = 0;
  int total  = 0;
  logic [4:0] good [4];

  always #5 clk = ~clk;

  arith_resp_checker #(.NUM_VECTORS(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c(c), .d(d), .e(e), .busy(busy), .done(done), .pass(pass),
    .vec_count(vec_count), .err_count(err_count),
    .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
  );

  arith_resp_checker #(.NUM_VECTORS(3), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .c(c), .d(d), .e(e), .busy(busy2), .done(done2), .pass(pass2),
    .vec_count(vec_count2), .err_count(err_count2),
    .first_fail_valid(first_fail_valid2), .first_fail_idx(first_fail_idx2)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic pulse_start(input logic narrow);
    if (narrow) start2 = 1'b1; else start = 1'b1;
    @(negedge clk);
    start = 1'b0; start2 = 1'b0;
  endtask

  task automatic drive_vec(input logic [4:0] v);
    {a, b, c, d, e} = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++; if ({in_ready, busy, done, pass, first_fail_valid} !== 5'b0) $display("FAIL reset_flags got %b want 00000", {in_ready, busy, done, pass, first_fail_valid}); else passed++;
    total++; if ({vec_count, err_count, first_fail_idx} !== 24'h0) $display("FAIL reset_counts got %h want 000000", {vec_count, err_count, first_fail_idx}); else passed++;
    total++; if ({in_ready2, busy2, done2, pass2, vec_count2, err_count2} !== 8'h0) $display("FAIL reset_narrow got %h want 00", {in_ready2, busy2, done2, pass2, vec_count2, err_count2}); else passed++;
    rst = 1'b0;
  endtask

  task automatic test_all_pass();
    pulse_start(1'b0);
    total++; if ({in_ready, busy, done} !== 3'b110) $display("FAIL all_pass_run got %b want 110", {in_ready, busy, done}); else passed++;
    for (int i = 0; i < 3; i++) drive_vec(good[i]);
    total++; if (done !== 1'b0 || vec_count !== 8'd3) $display("FAIL all_pass_early got done=%b vec=%0d want done=0 vec=3", done, vec_count); else passed++;
    drive_vec(good[3]);
    total++; if ({done, busy, in_ready, pass} !== 4'b1001) $display("FAIL all_pass_flags got %b want 1001", {done, busy, in_ready, pass}); else passed++;
    total++; if (vec_count !== 8'd4 || err_count !== 8'd0) $display("FAIL all_pass_counts got vec=%0d err=%0d want 4 0", vec_count, err_count); else passed++;
    total++; if (first_fail_valid !== 1'b0) $display("FAIL all_pass_ffv got %b want 0", first_fail_valid); else passed++;
  endtask

  task automatic test_single_fault();
    pulse_start(1'b0);
    total++; if (vec_count !== 8'd0 || done !== 1'b0) $display("FAIL single_clear got vec=%0d done=%b want 0 0", vec_count, done); else passed++;
    drive_vec(good[0]);
    drive_vec(good[1]);
    drive_vec(5'b10_000);
    drive_vec(good[3]);
    total++; if (err_count !== 8'd1 || vec_count !== 8'd4) $display("FAIL single_counts got err=%0d vec=%0d want 1 4", err_count, vec_count); else passed++;
    total++; if (first_fail_valid !== 1'b1 || first_fail_idx !== 8'd2) $display("FAIL single_ff got v=%b idx=%0d want 1 2", first_fail_valid, first_fail_idx); else passed++;
    total++; if (done !== 1'b1 || pass !== 1'b0) $display("FAIL single_pass got done=%b pass=%b want 1 0", done, pass); else passed++;
  endtask

  task automatic test_multi_fault();
    pulse_start(1'b0);
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      {a, b, c, d, e} = good[i % 4] ^ 5'b00001;
      @(negedge clk);
      if (i == 3) begin
        total++; if (done !== 1'b1 || in_ready !== 1'b0) $display("FAIL multi_done got done=%b rdy=%b want 1 0", done, in_ready); else passed++;
      end
    end
    in_valid = 1'b0;
    total++; if (vec_count !== 8'd4 || err_count !== 8'd4) $display("FAIL multi_counts got vec=%0d err=%0d want 4 4", vec_count, err_count); else passed++;
    total++; if (first_fail_valid !== 1'b1 || first_fail_idx !== 8'd0) $display("FAIL multi_ff got v=%b idx=%0d want 1 0", first_fail_valid, first_fail_idx); else passed++;
    total++; if (pass !== 1'b0) $display("FAIL multi_pass got %b want 0", pass); else passed++;
  endtask

  task automatic test_protocol();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    {a, b, c, d, e} = good[1];
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (vec_count !== 8'd0 || in_ready !== 1'b0 || busy !== 1'b0) $display("FAIL proto_idle%0d got vec=%0d rdy=%b busy=%b want 0 0 0", i, vec_count, in_ready, busy); else passed++;
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    total++; if (vec_count !== 8'd0 || in_ready !== 1'b1) $display("FAIL proto_start_valid got vec=%0d rdy=%b want 0 1", vec_count, in_ready); else passed++;
    drive_vec(good[0]);
    drive_vec(good[1]);
    start = 1'b1;
    drive_vec(good[2]);
    start = 1'b0;
    total++; if (vec_count !== 8'd3 || busy !== 1'b1 || done !== 1'b0) $display("FAIL proto_midstart got vec=%0d busy=%b done=%b want 3 1 0", vec_count, busy, done); else passed++;
    drive_vec(good[3]);
    total++; if (done !== 1'b1 || pass !== 1'b1 || vec_count !== 8'd4) $display("FAIL proto_end got done=%b pass=%b vec=%0d want 1 1 4", done, pass, vec_count); else passed++;
  endtask

  task automatic test_reset_mid_run();
    pulse_start(1'b0);
    drive_vec(5'b00_111);
    drive_vec(good[1]);
    rst = 1'b1; start = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    total++; if ({in_ready, busy, done, pass, first_fail_valid} !== 5'b0) $display("FAIL rstmid_flags got %b want 00000", {in_ready, busy, done, pass, first_fail_valid}); else passed++;
    total++; if ({vec_count, err_count, first_fail_idx} !== 24'h0) $display("FAIL rstmid_counts got %h want 000000", {vec_count, err_count, first_fail_idx}); else passed++;
    rst = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || in_ready !== 1'b0) $display("FAIL rstmid_idle got busy=%b rdy=%b want 0 0", busy, in_ready); else passed++;
    pulse_start(1'b0);
    for (int i = 0; i < 4; i++) drive_vec(good[i]);
    total++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 8'd0) $display("FAIL rstmid_rerun got done=%b pass=%b err=%0d want 1 1 0", done, pass, err_count); else passed++;
  endtask

  task automatic test_restart_saturation();
    pulse_start(1'b1);
    for (int i = 0; i < 3; i++) drive_vec(good[i] ^ 5'b00100);
    total++; if (done2 !== 1'b1 || err_count2 !== 2'd3 || vec_count2 !== 2'd3 || pass2 !== 1'b0) $display("FAIL sat_run1 got done=%b err=%0d vec=%0d pass=%b want 1 3 3 0", done2, err_count2, vec_count2, pass2); else passed++;
    pulse_start(1'b1);
    total++; if ({vec_count2, err_count2, first_fail_valid2, done2, busy2} !== 7'b0000_001) $display("FAIL sat_restart got %b want 0000001", {vec_count2, err_count2, first_fail_valid2, done2, busy2}); else passed++;
    for (int i = 1; i < 4; i++) drive_vec(good[i] ^ 5'b00010);
    total++; if (err_count2 !== 2'd3 || pass2 !== 1'b0 || first_fail_idx2 !== 2'd0) $display("FAIL sat_run2 got err=%0d pass=%b idx=%0d want 3 0 0", err_count2, pass2, first_fail_idx2); else passed++;
    drive_vec(5'b11_111);
    drive_vec(5'b01_000);
    total++; if (err_count2 !== 2'd3 || vec_count2 !== 2'd3 || done2 !== 1'b1) $display("FAIL sat_hold got err=%0d vec=%0d done=%b want 3 3 1", err_count2, vec_count2, done2); else passed++;
  endtask

  initial begin
    good[0] = 5'b00_000;
    good[1] = 5'b01_101;
    good[2] = 5'b10_100;
    good[3] = 5'b11_010;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; in_valid = 1'b0;
    {a, b, c, d, e} = 5'b0;
    test_reset();
    test_all_pass();
    test_single_fault();
    test_multi_fault();
    test_protocol();
    test_reset_mid_run();
    test_restart_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
